// File: rtl/noc_output_ctrl.sv
// Per-port router output stage: two single-phase VC FIFOs (even/odd) written by the
// arbitrators and drained onto the link from the VC opposite the current polarity.
module noc_output_ctrl #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              even_out_enable,
    input  logic [DATA_W-1:0] even_out_data,
    input  logic              odd_out_enable,
    input  logic [DATA_W-1:0] odd_out_data,
    output logic              even_out_empty,
    output logic              odd_out_empty,
    output logic              so,
    input  logic              ro,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  sent_count,
    output logic              overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    // Index 0 is the even VC, index 1 the odd VC; storage is padded to a power of two.
    logic [DATA_W-1:0] mem   [2][1 << PTR_W];
    logic [PTR_W-1:0]  head  [2];
    logic [PTR_W-1:0]  tail  [2];
    logic [OCC_W-1:0]  count [2];

    logic              wr_vc;
    logic              rd_vc;
    logic              wr_en;
    logic              wrong_en;
    logic              wr_fire;
    logic              rd_fire;
    logic              err_set;
    logic [DATA_W-1:0] wr_data;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Writable and draining VCs are always different, so the two paths never collide.
    always_comb begin
        wr_vc    = polarity;
        rd_vc    = ~polarity;
        wr_en    = polarity ? odd_out_enable : even_out_enable;
        wrong_en = polarity ? even_out_enable : odd_out_enable;
        wr_data  = polarity ? odd_out_data : even_out_data;
        wr_fire  = wr_en && (count[wr_vc] != FULL);
        rd_fire  = ro && (count[rd_vc] != '0);
        err_set  = wrong_en || (wr_en && !wr_fire);
    end

    assign even_out_empty = (count[0] != FULL);
    assign odd_out_empty  = (count[1] != FULL);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_vc][tail[wr_vc]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < 2; v++) begin
                head[v]  <= '0;
                tail[v]  <= '0;
                count[v] <= '0;
            end
            so           <= 1'b0;
            dout         <= '0;
            sent_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (wr_fire) begin
                tail[wr_vc]  <= next_ptr(tail[wr_vc]);
                count[wr_vc] <= count[wr_vc] + OCC_W'(1);
            end
            if (rd_fire) begin
                head[rd_vc]  <= next_ptr(head[rd_vc]);
                count[rd_vc] <= count[rd_vc] - OCC_W'(1);
                dout         <= mem[rd_vc][head[rd_vc]];
                sent_count   <= sent_count + CNT_W'(1);
            end
            so <= rd_fire;
            if (err_set) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_output_ctrl.sv
// Bench for noc_output_ctrl: a DEPTH=1/CNT_W=16 and a DEPTH=4/CNT_W=4 instance share
// stimulus and are both compared against a queue-based model of the VC buffers.
module tb_noc_output_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        even_en;
    logic [63:0] even_data;
    logic        odd_en;
    logic [63:0] odd_data;
    logic        ro;

    logic        e_empty1, o_empty1, so1, err1;
    logic [63:0] dout1;
    logic [15:0] sent1;
    logic        e_empty4, o_empty4, so4, err4;
    logic [63:0] dout4;
    logic [3:0]  sent4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_output_ctrl #(.DATA_W(64), .DEPTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .polarity(polarity),
        .even_out_enable(even_en), .even_out_data(even_data),
        .odd_out_enable(odd_en), .odd_out_data(odd_data),
        .even_out_empty(e_empty1), .odd_out_empty(o_empty1),
        .so(so1), .ro(ro), .dout(dout1), .sent_count(sent1), .overflow_err(err1)
    );

    noc_output_ctrl #(.DATA_W(64), .DEPTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .polarity(polarity),
        .even_out_enable(even_en), .even_out_data(even_data),
        .odd_out_enable(odd_en), .odd_out_data(odd_data),
        .even_out_empty(e_empty4), .odd_out_empty(o_empty4),
        .so(so4), .ro(ro), .dout(dout4), .sent_count(sent4), .overflow_err(err4)
    );

    // Instance 0 is the DEPTH=1 part, instance 1 the DEPTH=4 part.
    logic        so_w    [2];
    logic        err_w   [2];
    logic        eemp_w  [2];
    logic        oemp_w  [2];
    logic [63:0] dout_w  [2];
    logic [15:0] sent_w  [2];
    assign so_w[0]   = so1;      assign so_w[1]   = so4;
    assign err_w[0]  = err1;     assign err_w[1]  = err4;
    assign eemp_w[0] = e_empty1; assign eemp_w[1] = e_empty4;
    assign oemp_w[0] = o_empty1; assign oemp_w[1] = o_empty4;
    assign dout_w[0] = dout1;    assign dout_w[1] = dout4;
    assign sent_w[0] = sent1;    assign sent_w[1] = {12'b0, sent4};

    int          mdepth [2] = '{1, 4};
    int          mmod   [2] = '{65536, 16};
    logic [63:0] mq     [4][$];
    logic        m_so   [2];
    logic        m_err  [2];
    logic [63:0] m_dout [2];
    int          m_sent [2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mq[2*i].delete();
            mq[2*i+1].delete();
            m_so[i]   = 1'b0;
            m_err[i]  = 1'b0;
            m_dout[i] = '0;
            m_sent[i] = 0;
        end
    endtask

    task automatic model_edge();
        int          wv, dv;
        logic        wen, oen;
        logic [63:0] wd;
        if (reset) begin
            model_clear();
            return;
        end
        wv  = polarity ? 1 : 0;
        dv  = 1 - wv;
        wen = polarity ? odd_en : even_en;
        oen = polarity ? even_en : odd_en;
        wd  = polarity ? odd_data : even_data;
        for (int i = 0; i < 2; i++) begin
            if (oen) m_err[i] = 1'b1;
            if (wen) begin
                if (mq[2*i+wv].size() < mdepth[i]) mq[2*i+wv].push_back(wd);
                else m_err[i] = 1'b1;
            end
            if (ro && mq[2*i+dv].size() > 0) begin
                m_dout[i] = mq[2*i+dv].pop_front();
                m_so[i]   = 1'b1;
                m_sent[i] = (m_sent[i] + 1) % mmod[i];
            end else begin
                m_so[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic pol, input logic ee, input logic [63:0] ed,
                         input logic oe, input logic [63:0] od, input logic r);
        polarity = pol; even_en = ee; even_data = ed;
        odd_en = oe; odd_data = od; ro = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            drive(1'($urandom), 1'($urandom), {$urandom, $urandom},
                  1'($urandom), {$urandom, $urandom}, 1'($urandom));
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (so_w[i] !== 1'b0 || dout_w[i] !== 64'h0 || sent_w[i] !== 16'h0 ||
                    err_w[i] !== 1'b0 || eemp_w[i] !== 1'b1 || oemp_w[i] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL reset_state inst%0d got so=%b dout=%h sent=%0d err=%b ee=%b oe=%b required 0/0/0/0/1/1",
                             i, so_w[i], dout_w[i], sent_w[i], err_w[i], eemp_w[i], oemp_w[i]);
                end
            end
        end
        reset = 1'b0;
        drive(1'b0, 1'b1, 64'h8000_0000_0000_00AA, 1'b0, '0, 1'b0);
        tick();
        checks++;
        if (e_empty1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_write_full got %b required 0", e_empty1);
        end
        checks++;
        if (e_empty4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_write_depth4 got %b required 1", e_empty4);
        end
    endtask

    task automatic test_cross_phase();
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (so_w[i] !== 1'b1 || dout_w[i] !== 64'h8000_0000_0000_00AA ||
                sent_w[i] !== 16'd1 || eemp_w[i] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL cross_phase inst%0d got so=%b dout=%h sent=%0d ee=%b required 1/80000000000000aa/1/1",
                         i, so_w[i], dout_w[i], sent_w[i], eemp_w[i]);
            end
        end
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        checks++;
        if (so1 !== 1'b0 || dout1 !== 64'h8000_0000_0000_00AA) begin
            errors++;
            $display("[TB] FAIL so_pulse got so=%b dout=%h required 0/80000000000000aa", so1, dout1);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b0, 1'b1, 64'h8000_0000_0000_00AA, 1'b0, '0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
            tick();
            checks++;
            if (so1 !== 1'b0 || so4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_%0d got so=%b/%b required 0/0", k, so1, so4);
            end
        end
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (so_w[i] !== 1'b1 || dout_w[i] !== 64'h8000_0000_0000_00AA || sent_w[i] !== 16'(m_sent[i])) begin
                errors++;
                $display("[TB] FAIL release inst%0d got so=%b dout=%h sent=%0d required 1/80000000000000aa/%0d",
                         i, so_w[i], dout_w[i], sent_w[i], m_sent[i]);
            end
        end
        tick();
        checks++;
        if (so1 !== 1'b0 || so4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pulse got so=%b/%b required 0/0", so1, so4);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp_v;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b0, '0, 1'b1, 64'(k), 1'b0);
            tick();
            checks++;
            if (err4 !== (k == 5)) begin
                errors++;
                $display("[TB] FAIL overflow_write%0d got %b required %b", k, err4, (k == 5));
            end
            drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
            tick();
        end
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_depth1 got %b required 1", err1);
        end
        // Drain 1..4, refill 6..9 across the pointer wrap, drain again.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                exp_v = 64'(pass * 5 + k + 1);
                drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
                tick();
                checks++;
                if (so4 !== 1'b1 || dout4 !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL order_p%0d_%0d got so=%b dout=%h required 1/%h", pass, k, so4, dout4, exp_v);
                end
            end
            if (pass == 0) begin
                for (int k = 6; k <= 9; k++) begin
                    drive(1'b1, 1'b0, '0, 1'b1, 64'(k), 1'b0);
                    tick();
                end
            end
        end
    endtask

    task automatic test_wrong_vc();
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b1, 64'h55, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (err_w[i] !== 1'b1 || oemp_w[i] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL wrong_vc inst%0d cyc%0d got err=%b oe=%b required 1/1", i, k, err_w[i], oemp_w[i]);
                end
            end
            drive(1'(k), 1'b0, '0, 1'b0, '0, 1'b1);
            tick();
        end
        checks++;
        if (so1 !== 1'b0 || sent1 !== 16'd0) begin
            errors++;
            $display("[TB] FAIL wrong_vc_nosend got so=%b sent=%0d required 0/0", so1, sent1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 64'hA0 + 64'(k), 1'b0, '0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        checks++;
        if (so4 !== 1'b1 || dout4 !== 64'hA0) begin
            errors++;
            $display("[TB] FAIL pre_reset_send got so=%b dout=%h required 1/a0", so4, dout4);
        end
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (so_w[i] !== 1'b0 || dout_w[i] !== 64'h0 || sent_w[i] !== 16'h0 ||
                err_w[i] !== 1'b0 || eemp_w[i] !== 1'b1 || oemp_w[i] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL async_clear inst%0d got so=%b dout=%h sent=%0d err=%b ee=%b oe=%b required 0/0/0/0/1/1",
                         i, so_w[i], dout_w[i], sent_w[i], err_w[i], eemp_w[i], oemp_w[i]);
            end
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'(k), 1'b0, '0, 1'b0, '0, 1'b1);
            tick();
            checks++;
            if (so1 !== 1'b0 || so4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_so%0d got %b/%b required 0/0", k, so1, so4);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, 1'b0, '0, 1'b1, 64'(16 * r + k), 1'b1);
                tick();
            end
            for (int k = 0; k < 4; k++) begin
                drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
                tick();
            end
        end
        checks++;
        if (sent4 !== 4'd0) begin
            errors++;
            $display("[TB] FAIL sent_wrap got %0d required 0", sent4);
        end
        checks++;
        if (sent1 !== 16'(m_sent[0])) begin
            errors++;
            $display("[TB] FAIL sent_depth1 got %0d required %0d", sent1, m_sent[0]);
        end
    endtask

    task automatic test_random();
        logic pol;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            pol = 1'($urandom);
            drive(pol,
                  pol ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 9) < 6), {$urandom, $urandom},
                  pol ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 49) == 0), {$urandom, $urandom},
                  ($urandom_range(0, 9) < 6));
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (so_w[i] !== m_so[i] || dout_w[i] !== m_dout[i] || sent_w[i] !== 16'(m_sent[i]) ||
                    err_w[i] !== m_err[i] ||
                    eemp_w[i] !== (mq[2*i].size() < mdepth[i]) ||
                    oemp_w[i] !== (mq[2*i+1].size() < mdepth[i])) begin
                    errors++;
                    $display("[TB] FAIL random inst%0d cyc%0d got so=%b dout=%h sent=%0d err=%b ee=%b oe=%b required %b/%h/%0d/%b/%b/%b",
                             i, k, so_w[i], dout_w[i], sent_w[i], err_w[i], eemp_w[i], oemp_w[i],
                             m_so[i], m_dout[i], m_sent[i], m_err[i],
                             (mq[2*i].size() < mdepth[i]), (mq[2*i+1].size() < mdepth[i]));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        model_clear();
        test_reset();
        test_cross_phase();
        test_backpressure();
        test_overflow();
        test_wrong_vc();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_output_ctrl.md
Name: noc_output_ctrl

Overview:
- Per-port output stage of the mesh router, directly downstream of the even/odd four-way arbitrators.
- Holds granted flits in two virtual-channel FIFOs (even VC, odd VC), one per arbitrator, and reports free space back to them.
- Drains the VC opposite to the one being written onto the inter-router (or PE) link using a send/ready handshake.
- One instance per output direction: UP, DOWN, LEFT, RIGHT, PE.

Parameters:
DATA_W, 64, flit width; bit 63 is the VC bit, passed unchanged.
DEPTH, 1, entries per VC FIFO, 1..8.
CNT_W, 16, width of the sent-flit counter.

Ports:
clk  input  1  router clock
reset  input  1  asynchronous active-high reset
polarity  input  1  router phase; 0: even VC writable / odd VC drains, 1: odd VC writable / even VC drains
even_out_enable  input  1  write strobe from even arbitrator
even_out_data  input  DATA_W  flit from even arbitrator
odd_out_enable  input  1  write strobe from odd arbitrator
odd_out_data  input  DATA_W  flit from odd arbitrator
even_out_empty  output  1  even FIFO has ≥1 free slot (combinational from count)
odd_out_empty  output  1  odd FIFO has ≥1 free slot
so  output  1  send-out strobe to downstream link, registered
ro  input  1  downstream ready (downstream input buffer of the draining VC is empty)
dout  output  DATA_W  link data, registered
sent_count  output  CNT_W  flits sent since reset, wraps
overflow_err  output  1  sticky: write attempted to a full FIFO or to the non-writable VC

Behaviour:
- Reset (asynchronous, active-high): both FIFOs empty (count=0, pointers=0); so=0; dout=0; sent_count=0; overflow_err=0. As a result, even_out_empty=1 and odd_out_empty=1 while reset is held.
- Reset mid-operation discards every buffered flit. No partial send is emitted after reset deasserts.
- FIFOs are circular with a per-VC head pointer, tail pointer and count (0..DEPTH). Pointers wrap from DEPTH-1 to 0.
- Write, even VC: on the edge where polarity=0, even_out_enable=1 and count<DEPTH, store even_out_data at the tail and increment the tail pointer and count. The odd VC behaves the same with polarity=1 and odd_out_enable.
- Write to a full FIFO: dropped, FIFO unchanged, overflow_err set.
- Enable on the non-writable VC for the current polarity: dropped, overflow_err set.
- Drain: on the edge where the draining VC (odd if polarity=0, even if polarity=1) has count>0 and ro=1:
  - dout <= head flit, so <= 1;
  - head pointer and count of that VC advance;
  - sent_count increments, wrapping at 2^CNT_W.
- No drain on an edge: so <= 0 and dout holds its last value.
- so is therefore a 1-cycle pulse per flit. Latency from write to so is at least 2 edges, because the flit must wait for the opposite polarity.
- A single VC never sees a write and a read on the same edge: writable and draining VCs always differ, so no simultaneous-access case exists.
- ro is sampled only at the clock edge. ro=0 stalls the drain and the flit stays at the head.
- FIFO order is strict within each VC. There is no ordering between VCs.
- The data payload, including bit 63 and the hop fields, is never modified here.
- With DEPTH=1, even_out_empty is exactly "buffer empty".

Test Plan:
- Reset held with random inputs -> so=0, dout=0, both *_empty=1, sent_count=0, overflow_err=0. Release reset, hold polarity=0, write even flit 64'h8000_0000_0000_00AA -> even_out_empty=0 after the edge.
- Cross-phase delivery: even flit 0xAA written at polarity=0, polarity=1 on the next edge with ro=1 -> so=1 and dout=0xAA one cycle later, sent_count=1, even_out_empty=1.
- Backpressure: same flit held with ro=0 for 3 drain phases, then ro=1 -> so stays 0 for those 3 phases, then exactly one so pulse with dout=0xAA.
- DEPTH=4, polarity alternating, 5 odd writes of 0x1..0x5 with ro=0 -> 5th write dropped and overflow_err=1. After ro=1 the flits drain in order 0x1..0x4, with wrap-around checked by continuing with 4 more writes.
- Odd enable asserted while polarity=0 -> write ignored, odd count unchanged, overflow_err=1 sticky until reset.
- Reset asserted asynchronously mid-cycle with 2 flits buffered -> outputs clear immediately without a clock edge. No so pulse after release. sent_count wrap checked with CNT_W=4: 16 sends -> sent_count=0.
